// File: rtl/mean_divider.sv
// mean_divider: streaming mean stage. Accumulates unsigned samples and their
// count, then divides sum by count with a bit-serial restoring divider and
// presents the mean with a one-cycle valid pulse.
// Optional build macro: MEAN_DIV_ROUND_EN (round to nearest, ties up).
module mean_divider #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic              last,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_count,
    output logic [DATA_W-1:0] mean_out,
    output logic              mean_valid,
    output logic              dropped
);

    localparam int ACC_W  = DATA_W + CNT_W;
    localparam int STEP_W = $clog2(ACC_W + 1);

    typedef enum logic [1:0] {
        ST_ACC,
        ST_DIV,
        ST_OUT
    } state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc_q;
    logic [CNT_W-1:0]   count_q;
    // Dividend bits shift out at the top while quotient bits shift in at the
    // bottom, so after ACC_W steps this register holds the quotient.
    logic [ACC_W-1:0]   dvd_q;
    logic [CNT_W:0]     rem_q;
    logic [STEP_W-1:0]  step_q;

    logic [ACC_W-1:0]   acc_sum;
    logic [CNT_W-1:0]   count_inc;
    logic               scan_end;
    logic [ACC_W-1:0]   dividend_load;
    logic [CNT_W+1:0]   rem_shift;
    logic [CNT_W:0]     rem_trial;
    logic               rem_ge;

    assign sample_count = count_q;

    // Next-sum, scan termination and one restoring-division trial step.
    // NOTE: every signal gets an unconditional assignment here, so no latch is inferred.
    always_comb begin
        acc_sum   = acc_q + ACC_W'(sample_in);
        count_inc = count_q + CNT_W'(1);
        // The 31st sample (count at 2^CNT_W-2 before it) forces the end of the scan.
        scan_end  = last || (count_q == CNT_W'((1 << CNT_W) - 2));
`ifdef MEAN_DIV_ROUND_EN
        // Adding half the divisor turns truncation into round-half-up.
        dividend_load = acc_sum + ACC_W'(count_inc >> 1);
`else
        dividend_load = acc_sum;
`endif
        rem_shift = {rem_q, dvd_q[ACC_W-1]};
        rem_ge    = rem_shift >= {2'b00, count_q};
        // The shifted remainder is below twice the divisor, so the low bits suffice.
        rem_trial = rem_shift[CNT_W:0] - {1'b0, count_q};
    end

    // Control FSM with datapath: accumulate, divide, present the result.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_ACC;
            acc_q      <= '0;
            count_q    <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            step_q     <= '0;
            busy       <= 1'b0;
            mean_out   <= '0;
            mean_valid <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (sample_valid) begin
                        count_q <= count_inc;
                        if (scan_end) begin
                            dvd_q  <= dividend_load;
                            rem_q  <= '0;
                            step_q <= '0;
                            acc_q  <= '0;
                            busy   <= 1'b1;
                            state  <= ST_DIV;
                        end else begin
                            acc_q <= acc_sum;
                        end
                    end
                end
                ST_DIV: begin
                    if (sample_valid) dropped <= 1'b1;
                    if (step_q == STEP_W'(ACC_W)) begin
                        // Quotient never exceeds the largest sample, so the slice is lossless.
                        mean_out   <= dvd_q[DATA_W-1:0];
                        mean_valid <= 1'b1;
                        state      <= ST_OUT;
                    end else begin
                        dvd_q  <= {dvd_q[ACC_W-2:0], rem_ge};
                        rem_q  <= rem_ge ? rem_trial : rem_shift[CNT_W:0];
                        step_q <= step_q + STEP_W'(1);
                    end
                end
                ST_OUT: begin
                    if (sample_valid) dropped <= 1'b1;
                    mean_valid <= 1'b0;
                    busy       <= 1'b0;
                    count_q    <= '0;
                    acc_q      <= '0;
                    state      <= ST_ACC;
                end
                default: state <= ST_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mean_divider.sv
// Directed self-checking bench for mean_divider.
module tb_mean_divider;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 5;

`ifdef MEAN_DIV_ROUND_EN
    localparam int EXP_ONE_TWO = 2;
`else
    localparam int EXP_ONE_TWO = 1;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic              last;
    logic              busy;
    logic [CNT_W-1:0]  sample_count;
    logic [DATA_W-1:0] mean_out;
    logic              mean_valid;
    logic              dropped;

    int checks = 0;
    int errors = 0;

    mean_divider #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .last         (last),
        .busy         (busy),
        .sample_count (sample_count),
        .mean_out     (mean_out),
        .mean_valid   (mean_valid),
        .dropped      (dropped)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] s, input logic l);
        sample_in    = s;
        sample_valid = 1'b1;
        last         = l;
        step();
        sample_valid = 1'b0;
        last         = 1'b0;
        sample_in    = '0;
    endtask

    // Step until mean_valid is seen or the budget runs out.
    task automatic wait_mean(input int budget, output int cycles, output logic seen);
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            step();
            cycles++;
            if (mean_valid) seen = 1'b1;
        end
    endtask

    initial begin
        int   cyc;
        logic seen;

        reset        = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        last         = 1'b0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_count", sample_count, 0);
        check("rst_mean", mean_out, 0);
        check("rst_valid", mean_valid, 0);
        check("rst_dropped", dropped, 0);
        reset = 1'b0;
        step();

        // Scan 1: 10,20,30,41 -> 101/4 = 25, latency 22 cycles.
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        send(16'd30, 1'b0);
        check("s1_count3", sample_count, 3);
        check("s1_busy_acc", busy, 0);
        send(16'd41, 1'b1);
        check("s1_busy_div", busy, 1);
        check("s1_count4", sample_count, 4);
        wait_mean(40, cyc, seen);
        check("s1_seen", seen, 1);
        check("s1_latency", cyc, 22);
        check("s1_mean", mean_out, 25);
        check("s1_busy_out", busy, 1);
        step();
        check("s1_valid_drop", mean_valid, 0);
        check("s1_busy_drop", busy, 0);
        check("s1_count_clr", sample_count, 0);
        check("s1_mean_hold", mean_out, 25);

        // last without sample_valid is ignored.
        last = 1'b1;
        step();
        last = 1'b0;
        check("ign_last_busy", busy, 0);
        check("ign_last_count", sample_count, 0);

        // Scan 2: 1,2 -> 3/2 truncates to 1, rounds to 2.
        send(16'd1, 1'b0);
        send(16'd2, 1'b1);
        wait_mean(40, cyc, seen);
        check("s2_seen", seen, 1);
        check("s2_mean", mean_out, EXP_ONE_TWO);
        step();

        // Scan 3: 16 x 0xFFFF -> 0xFFFF.
        for (int i = 0; i < 16; i++) send(16'hFFFF, (i == 15));
        step();
        step();
        step();
        check("s3_count_div", sample_count, 16);
        check("s3_busy", busy, 1);
        wait_mean(40, cyc, seen);
        check("s3_seen", seen, 1);
        check("s3_mean", mean_out, 16'hFFFF);
        step();

        // Scan 4: 31 x 7 with no last -> forced division after the 31st.
        for (int i = 0; i < 30; i++) send(16'd7, 1'b0);
        check("s4_busy_30", busy, 0);
        check("s4_count_30", sample_count, 30);
        send(16'd7, 1'b0);
        check("s4_busy_31", busy, 1);
        check("s4_count_31", sample_count, 31);
        wait_mean(40, cyc, seen);
        check("s4_seen", seen, 1);
        check("s4_mean", mean_out, 7);
        check("s4_count_out", sample_count, 31);
        step();

        // Scan 5: 100,200 then 3,5 pushed while busy, then 3,5 after re-arm.
        send(16'd100, 1'b0);
        send(16'd200, 1'b1);
        check("s5_no_drop_yet", dropped, 0);
        send(16'd3, 1'b0);
        send(16'd5, 1'b1);
        check("s5_dropped", dropped, 1);
        wait_mean(40, cyc, seen);
        check("s5_seen", seen, 1);
        check("s5_first_mean", mean_out, 150);
        step();
        send(16'd3, 1'b0);
        send(16'd5, 1'b1);
        wait_mean(40, cyc, seen);
        check("s5_seen2", seen, 1);
        check("s5_second_mean", mean_out, 4);
        check("s5_dropped_sticky", dropped, 1);
        step();

        // Scan 6: reset mid-division, then 8,8 -> 8.
        send(16'd50, 1'b0);
        send(16'd60, 1'b1);
        for (int i = 0; i < 10; i++) step();
        check("s6_busy_before", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("s6_async_busy", busy, 0);
        check("s6_async_mean", mean_out, 0);
        check("s6_async_count", sample_count, 0);
        check("s6_async_dropped", dropped, 0);
        check("s6_async_valid", mean_valid, 0);
        step();
        reset = 1'b0;
        wait_mean(30, cyc, seen);
        check("s6_no_valid", seen, 0);
        send(16'd8, 1'b0);
        send(16'd8, 1'b1);
        wait_mean(40, cyc, seen);
        check("s6_seen", seen, 1);
        check("s6_latency", cyc, 22);
        check("s6_mean", mean_out, 8);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mean_divider.md
# mean_divider

Streaming mean stage directly downstream of the sample memory controller. It accepts one 16-bit unsigned sample per cycle and keeps a running sum and count. When the scan-done marker arrives with a sample, it runs a bit-serial restoring division of the sum by the count. It then presents the mean with a one-cycle valid pulse and re-arms for the next scan.

## Interface
- DATA_W, 16: sample and mean width (unsigned).
- CNT_W, 5: sample counter width; maximum samples per scan = 2^CNT_W − 1.
- ACC_W, DATA_W+CNT_W: accumulator and dividend width; derived, do not override.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- sample_in  in  DATA_W  sample from the memory controller.
- sample_valid  in  1  sample_in is meaningful this cycle.
- last  in  1  scan-done marker; honoured only when sample_valid=1.
- busy  out  1  high in DIV and OUT; samples are not accepted.
- sample_count  out  CNT_W  samples accepted in the current scan.
- mean_out  out  DATA_W  last computed mean; holds until next result.
- mean_valid  out  1  one-cycle pulse when mean_out updates.
- dropped  out  1  sticky; set when a sample arrives while busy; cleared only by reset.

## Operation
- Reset value of every output is 0. State after reset is ACC. acc=0, count=0.
- ACC: sample_valid=1 → acc += sample_in (zero-extended to ACC_W), count += 1.
- ACC exit: a sample accepted with last=1 causes that sample to be included, then a transition to DIV.
- ACC forced exit: a sample accepted when count == 2^CNT_W−2 (the 31st sample) is included and forces DIV even with last=0.
- last=1 with sample_valid=0 is ignored.
- DIV: restoring division, one quotient bit per cycle, MSB first, ACC_W iterations. Divisor = count (nonzero by construction). Remainder register width is CNT_W+1.
- OUT: mean_out ← quotient[DATA_W−1:0]. The quotient never exceeds the maximum sample, so truncation is lossless. mean_valid=1. Next state is ACC with acc=0 and count=0.
- sample_count shows count in ACC and holds the final count during DIV and OUT. It clears on the OUT→ACC edge.
- sample_valid=1 in DIV or OUT: the sample is ignored and dropped is set. last is ignored.
- Reset asserted mid-DIV or mid-OUT: the division is abandoned and no mean_valid is produced. mean_out=0.

## Timing
- Edge E0 accepts the final sample, so busy=1 from after E0.
- Edges E1..E_ACC_W perform the division steps.
- Edge E_ACC_W+1 registers mean_out and asserts mean_valid. At default parameters this is 22 cycles after E0.
- mean_valid and busy drop at the next edge, E_ACC_W+2. A sample presented in that same cycle is accepted as the first sample of the new scan.
- No back-pressure. The upstream stage must keep samples off the bus while busy=1; violations are flagged via dropped.

## Configuration
- MEAN_DIV_ROUND_EN defined: dividend = acc + (count >> 1), so the result rounds to nearest with ties rounded up. The dividend cannot overflow ACC_W at the maximum count.
- MEAN_DIV_ROUND_EN undefined: dividend = acc, so the result truncates toward zero.
- Latency is identical in both builds.

## Test plan
- Samples 10, 20, 30, 41 (last on 41), sum 101, count 4 → mean_out=25 in both builds, mean_valid exactly 22 cycles after the last sample.
- Samples 1, 2 (last on 2) → mean_out=1 without MEAN_DIV_ROUND_EN; mean_out=2 with it.
- 16 samples of 0xFFFF with last on the 16th → mean_out=0xFFFF, sample_count=16 during DIV.
- 31 samples of 7 with last never asserted → forced DIV after the 31st sample; mean_out=7, sample_count=31.
- Second scan of 3, 5 (last) presented during busy, then again after re-arm → dropped=1. The first result is unaffected; the post-re-arm scan yields mean_out=4.
- Reset pulse at cycle 10 of DIV → all outputs 0 asynchronously, no mean_valid. The next scan 8, 8 (last) yields mean_out=8.
